// File: rtl/clock_pkg.sv
// Shared constants, FSM encoding and character helpers for the serial time reporter.
package clock_pkg;

  localparam logic [7:0] COLON = 8'h3A;
  localparam logic [7:0] CR    = 8'h0D;
  localparam logic [7:0] LF    = 8'h0A;
  localparam logic [7:0] QMARK = 8'h3F;
  localparam logic [7:0] ZERO  = 8'h30;

  localparam int unsigned FRAME_CHARS = 10;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
    ST_STOP
  } tx_state_t;

  // Frozen time snapshot, all digits BCD.
  typedef struct packed {
    logic [3:0] h1;
    logic [3:0] h2;
    logic [3:0] m1;
    logic [3:0] m2;
    logic [3:0] s1;
    logic [3:0] s2;
  } snap_t;

  function automatic int unsigned clks_per_bit(input int unsigned clk_hz,
                                               input int unsigned baud);
    return clk_hz / baud;
  endfunction

  function automatic logic [7:0] enc_digit(input logic [3:0] d);
    return (d > 4'd9) ? QMARK : ZERO + {4'b0000, d};
  endfunction

  // Out-of-range seconds map to 4'hF in both digits so each encodes as '?'.
  function automatic logic [7:0] secs_bcd(input logic [5:0] secs);
    if (secs > 6'd59) return 8'hFF;
    return {4'(secs / 6'd10), 4'(secs % 6'd10)};
  endfunction

  function automatic logic [7:0] char_at(input snap_t s, input logic [3:0] idx);
    case (idx)
      4'd0:    return enc_digit(s.h1);
      4'd1:    return enc_digit(s.h2);
      4'd2:    return COLON;
      4'd3:    return enc_digit(s.m1);
      4'd4:    return enc_digit(s.m2);
      4'd5:    return COLON;
      4'd6:    return enc_digit(s.s1);
      4'd7:    return enc_digit(s.s2);
      4'd8:    return CR;
      default: return LF;
    endcase
  endfunction

endpackage

// File: rtl/uart_tx_byte.sv
// 8N1 byte serializer. ready is high while idle and during the last STOP cycle,
// so a start seen then chains the next START with no idle gap.
module uart_tx_byte
  import clock_pkg::*;
#(
  parameter int unsigned CLKS_PER_BIT = 868
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic [7:0] data,
  output logic       ready,
  output logic       txd
);

  localparam int unsigned CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CW-1:0] LAST = CW'(CLKS_PER_BIT - 1);

  tx_state_t     state;
  logic [CW-1:0] baud_cnt;
  logic [2:0]    bit_idx;
  logic [7:0]    shreg;
  logic          bit_end_c;

  assign bit_end_c = (baud_cnt == LAST);

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= ST_IDLE;
      baud_cnt <= '0;
      bit_idx  <= '0;
      shreg    <= '0;
      txd      <= 1'b1;
      ready    <= 1'b1;
    end else begin
      case (state)
        ST_IDLE: begin
          if (start) begin
            state    <= ST_START;
            shreg    <= data;
            txd      <= 1'b0;
            ready    <= 1'b0;
            baud_cnt <= '0;
          end
        end
        ST_START: begin
          if (bit_end_c) begin
            state    <= ST_DATA;
            baud_cnt <= '0;
            bit_idx  <= '0;
            txd      <= shreg[0];
          end else begin
            baud_cnt <= baud_cnt + CW'(1);
          end
        end
        ST_DATA: begin
          if (bit_end_c) begin
            baud_cnt <= '0;
            if (bit_idx == 3'd7) begin
              state <= ST_STOP;
              txd   <= 1'b1;
              ready <= (LAST == '0);
            end else begin
              bit_idx <= bit_idx + 3'd1;
              shreg   <= {1'b1, shreg[7:1]};
              txd     <= shreg[1];
            end
          end else begin
            baud_cnt <= baud_cnt + CW'(1);
          end
        end
        ST_STOP: begin
          if (bit_end_c) begin
            baud_cnt <= '0;
            if (start) begin
              state <= ST_START;
              shreg <= data;
              txd   <= 1'b0;
              ready <= 1'b0;
            end else begin
              state <= ST_IDLE;
              ready <= 1'b1;
            end
          end else begin
            baud_cnt <= baud_cnt + CW'(1);
            ready    <= (baud_cnt == LAST - CW'(1));
          end
        end
        default: begin
          state <= ST_IDLE;
          txd   <= 1'b1;
          ready <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: rtl/time_uart_tx.sv
// Serial time reporter: snapshots the running time on request and sends
// "HH:MM:SS\r\n" as back-to-back 8N1 characters.
module time_uart_tx
  import clock_pkg::*;
#(
  parameter int unsigned CLK_HZ = 100_000_000,
  parameter int unsigned BAUD   = 115_200
) (
  input  logic       CLK100MHZ,
  input  logic       Reset,
  input  logic       send_req,
  input  logic [3:0] hours1,
  input  logic [3:0] hours2,
  input  logic [3:0] mins1,
  input  logic [3:0] mins2,
  input  logic [5:0] secs,
  output logic       UART_TXD,
  output logic       busy,
  output logic       done
);

  localparam int unsigned CLKS_PER_BIT = clks_per_bit(CLK_HZ, BAUD);

  snap_t      snap;
  snap_t      snap_in_c;
  logic [3:0] char_idx;
  logic       ready;
  logic       start_c;
  logic       last_char_c;
  logic [7:0] data_c;

  // The first character comes straight from the live inputs because the
  // serializer loads it on the same edge that captures the snapshot.
  always_comb begin
    snap_in_c   = {hours1, hours2, mins1, mins2, secs_bcd(secs)};
    last_char_c = (char_idx == 4'(FRAME_CHARS - 1));
    start_c     = busy ? (ready && !last_char_c) : send_req;
    data_c      = busy ? char_at(snap, char_idx + 4'd1) : char_at(snap_in_c, 4'd0);
  end

  always_ff @(posedge CLK100MHZ) begin
    if (Reset) begin
      busy     <= 1'b0;
      done     <= 1'b0;
      char_idx <= '0;
      snap     <= '0;
    end else begin
      done <= 1'b0;
      if (!busy) begin
        if (send_req) begin
          busy     <= 1'b1;
          char_idx <= '0;
          snap     <= snap_in_c;
        end
      end else if (ready) begin
        if (last_char_c) begin
          busy     <= 1'b0;
          done     <= 1'b1;
          char_idx <= '0;
        end else begin
          char_idx <= char_idx + 4'd1;
        end
      end
    end
  end

  uart_tx_byte #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_byte (
    .clk  (CLK100MHZ),
    .rst  (Reset),
    .start(start_c),
    .data (data_c),
    .ready(ready),
    .txd  (UART_TXD)
  );

endmodule

// File: tb/tb_time_uart_tx.sv
// Bench for time_uart_tx: table of time values with expected ASCII frames,
// a UART decoder feeding a byte scoreboard, and hand-written corner sequences.
module tb_time_uart_tx;

  localparam int CPB = 8;
  localparam int CPB_DEF = 868;

  logic       clk = 1'b0;
  logic       Reset = 1'b1;
  logic       send_req = 1'b0;
  logic [3:0] hours1 = '0, hours2 = '0, mins1 = '0, mins2 = '0;
  logic [5:0] secs = '0;
  logic       UART_TXD, busy, done;

  logic       reset_d = 1'b1;
  logic       req_d = 1'b0;
  logic       tx_d, busy_d, done_d;

  int n_checks = 0;
  int n_fail = 0;
  int done_cnt = 0;
  int frame_cnt = 0;
  bit mon_en = 1'b1;
  logic prev_busy = 1'b0;
  logic [7:0] sb[$];

  typedef struct {
    logic [3:0]  h1, h2, m1, m2;
    logic [5:0]  s;
    logic [79:0] exp;
  } vec_t;
  vec_t vecs[7];

  always #5 clk = ~clk;

  time_uart_tx #(.CLK_HZ(100_000_000), .BAUD(12_500_000)) dut (
    .CLK100MHZ(clk), .Reset(Reset), .send_req(send_req),
    .hours1(hours1), .hours2(hours2), .mins1(mins1), .mins2(mins2), .secs(secs),
    .UART_TXD(UART_TXD), .busy(busy), .done(done));

  time_uart_tx dut_def (
    .CLK100MHZ(clk), .Reset(reset_d), .send_req(req_d),
    .hours1(hours1), .hours2(hours2), .mins1(mins1), .mins2(mins2), .secs(secs),
    .UART_TXD(tx_d), .busy(busy_d), .done(done_d));

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic push_frame(input logic [79:0] exp);
    for (int k = 0; k < 10; k++) sb.push_back(exp[79-8*k -: 8]);
  endtask

  task automatic set_time(input vec_t v);
    hours1 = v.h1; hours2 = v.h2; mins1 = v.m1; mins2 = v.m2; secs = v.s;
  endtask

  // Done pulses and frame starts, with done never overlapping busy.
  always @(negedge clk) begin
    if (!Reset) begin
      if (done === 1'b1) begin
        done_cnt++;
        check("done_busy_low", 32'(busy), 32'd0);
      end
      if (busy === 1'b1 && prev_busy === 1'b0) frame_cnt++;
    end
    prev_busy <= busy;
  end

  // UART decoder: samples mid-bit on the falling clock edge.
  initial begin
    logic [7:0] b;
    logic st, sp;
    forever begin
      @(negedge clk);
      if (Reset === 1'b0 && UART_TXD === 1'b0) begin
        repeat (CPB/2) @(negedge clk);
        st = UART_TXD;
        for (int i = 0; i < 8; i++) begin
          repeat (CPB) @(negedge clk);
          b[i] = UART_TXD;
        end
        repeat (CPB) @(negedge clk);
        sp = UART_TXD;
        if (mon_en) begin
          check("rx_start_bit", 32'(st), 32'd0);
          check("rx_stop_bit", 32'(sp), 32'd1);
          if (sb.size() == 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL rx_unexpected: got byte %02h with empty scoreboard", b);
          end else begin
            check("rx_byte", 32'(b), 32'(sb.pop_front()));
          end
        end
      end
    end
  end

  // One request, one frame; optionally disturbs inputs and requests mid-frame.
  task automatic run_frame(input vec_t v, input bit perturb);
    int n;
    int d0;
    int f0;
    set_time(v);
    push_frame(v.exp);
    d0 = done_cnt;
    f0 = frame_cnt;
    send_req = 1'b1;
    tick();
    send_req = 1'b0;
    check("busy_rise", 32'(busy), 32'd1);
    check("first_start_bit", 32'(UART_TXD), 32'd0);
    n = 1;
    while (busy && n < 2000) begin
      tick();
      if (perturb && n == 170) begin
        hours1 = 4'd0; hours2 = 4'd0; mins1 = 4'd0; mins2 = 4'd0; secs = 6'd0;
        send_req = 1'b1;
      end
      if (n == 172) send_req = 1'b0;
      if (busy) n++;
    end
    send_req = 1'b0;
    check("busy_len", 32'(n), 32'(100*CPB));
    check("done_at_end", 32'(done), 32'd1);
    tick();
    check("done_one_cycle", 32'(done), 32'd0);
    repeat (3*CPB) tick();
    check("idle_after_frame", 32'(busy), 32'd0);
    check("done_count", 32'(done_cnt - d0), 32'd1);
    check("frame_count", 32'(frame_cnt - f0), 32'd1);
    check("sb_empty", 32'(sb.size()), 32'd0);
  endtask

  initial begin
    #900_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int n, nd, last, d0, f0;
    logic [7:0] b;

    vecs[0] = '{4'd1, 4'd2, 4'd3, 4'd4, 6'd56, 80'h31_32_3A_33_34_3A_35_36_0D_0A};
    vecs[1] = '{4'd2, 4'd3, 4'd5, 4'd9, 6'd59, 80'h32_33_3A_35_39_3A_35_39_0D_0A};
    vecs[2] = '{4'd1, 4'hC, 4'd0, 4'd7, 6'd63, 80'h31_3F_3A_30_37_3A_3F_3F_0D_0A};
    vecs[3] = '{4'd0, 4'd0, 4'd0, 4'd0, 6'd0,  80'h30_30_3A_30_30_3A_30_30_0D_0A};
    vecs[4] = '{4'hA, 4'd9, 4'd5, 4'hF, 6'd9,  80'h3F_39_3A_35_3F_3A_30_39_0D_0A};
    vecs[5] = '{4'd0, 4'd1, 4'd0, 4'd1, 6'd60, 80'h30_31_3A_30_31_3A_3F_3F_0D_0A};
    vecs[6] = '{4'd0, 4'd8, 4'd4, 4'd2, 6'd10, 80'h30_38_3A_34_32_3A_31_30_0D_0A};

    // Reset held: outputs at rest every cycle.
    for (int i = 0; i < 5; i++) begin
      tick();
      check("rst_txd", 32'(UART_TXD), 32'd1);
      check("rst_busy", 32'(busy), 32'd0);
      check("rst_done", 32'(done), 32'd0);
    end
    check("rst_def_txd", 32'(tx_d), 32'd1);
    check("rst_def_busy", 32'(busy_d), 32'd0);
    Reset = 1'b0;
    repeat (20) begin
      tick();
      if (UART_TXD !== 1'b1 || busy !== 1'b0) check("quiet_line", {UART_TXD, busy}, 32'b10);
    end
    check("quiet_txd", 32'(UART_TXD), 32'd1);
    check("quiet_busy", 32'(busy), 32'd0);

    // Table: every frame also changes inputs and pulses send_req mid-frame.
    for (int i = 0; i < 7; i++) run_frame(vecs[i], 1'b1);

    // send_req held: three frames back to back.
    set_time(vecs[3]);
    for (int k = 0; k < 3; k++) push_frame(vecs[3].exp);
    d0 = done_cnt;
    f0 = frame_cnt;
    send_req = 1'b1;
    tick();
    n = 0; nd = 0; last = 0;
    while (nd < 3 && n < 5000) begin
      tick();
      n++;
      if (done) begin
        nd++;
        check("held_done_busy", 32'(busy), 32'd0);
        if (nd > 1) check("held_period", 32'(n - last), 32'(100*CPB + 1));
        last = n;
        if (nd == 3) send_req = 1'b0;
        else begin
          tick();
          n++;
          check("held_restart_busy", 32'(busy), 32'd1);
          check("held_restart_start", 32'(UART_TXD), 32'd0);
        end
      end
    end
    send_req = 1'b0;
    check("held_dones", 32'(nd), 32'd3);
    repeat (3*CPB) tick();
    check("held_done_count", 32'(done_cnt - d0), 32'd3);
    check("held_frame_count", 32'(frame_cnt - f0), 32'd3);
    check("held_sb_empty", 32'(sb.size()), 32'd0);

    // Reset during D3 of character index 4.
    set_time(vecs[1]);
    push_frame(vecs[1].exp);
    d0 = done_cnt;
    send_req = 1'b1;
    tick();
    send_req = 1'b0;
    repeat (4*10*CPB + 4*CPB + 3) tick();
    check("pre_abort_busy", 32'(busy), 32'd1);
    check("pre_abort_sb", 32'(sb.size()), 32'd6);
    mon_en = 1'b0;
    Reset = 1'b1;
    tick();
    check("abort_txd", 32'(UART_TXD), 32'd1);
    check("abort_busy", 32'(busy), 32'd0);
    check("abort_done", 32'(done), 32'd0);
    tick();
    Reset = 1'b0;
    repeat (12*CPB) tick();
    check("abort_no_done", 32'(done_cnt - d0), 32'd0);
    check("abort_idle_txd", 32'(UART_TXD), 32'd1);
    sb.delete();
    mon_en = 1'b1;
    run_frame(vecs[0], 1'b0);

    // Default parameters: start bit length and first character.
    set_time(vecs[0]);
    reset_d = 1'b0;
    tick();
    req_d = 1'b1;
    tick();
    req_d = 1'b0;
    check("def_busy", 32'(busy_d), 32'd1);
    n = 1;
    while (tx_d === 1'b0 && n < 2000) begin
      tick();
      if (tx_d === 1'b0) n++;
    end
    check("def_start_len", 32'(n), 32'(CPB_DEF));
    repeat (CPB_DEF/2) tick();
    b[0] = tx_d;
    for (int i = 1; i < 8; i++) begin
      repeat (CPB_DEF) tick();
      b[i] = tx_d;
    end
    repeat (CPB_DEF) tick();
    check("def_stop", 32'(tx_d), 32'd1);
    check("def_byte0", 32'(b), 32'h31);
    check("def_still_busy", 32'(busy_d), 32'd1);
    reset_d = 1'b1;
    tick();
    check("def_reset_busy", 32'(busy_d), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
